mem_ctrl: RTL and testbench

//  Owns the single byte-wide RAM/IO port. Arbitrates between instruction-fetch misses (icache side)
//  and load/store requests (LSB side), then runs each grant as a byte-serial transaction.

---
 rtl/mem_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO port controller for icache fetches and LSB loads/stores
//
// Arbitrates icache fetch misses against LSB load/store requests (round-robin when both ask),
// then runs the granted access one byte per cycle over the single byte-wide memory port.
// Reads assemble 1/2/4 bytes little-endian; writes emit bytes LSB first.
// Optional feature macro: IO_WAIT_EN - stores into the IO region stall (WAIT_IO) while io_full.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; low pauses everything
//   clear                pipeline flush: aborts fetches/loads, never stores
//   ic_req/ic_addr       fetch request (4-byte word), held until ic_valid
//   ic_valid/ic_data     1-cycle pulse with the fetched word
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata   load/store request, held until ls_done
//   ls_done/ls_rdata     1-cycle pulse: store finished / zero-extended load data valid
//   mem_din              RAM read byte (for the address driven in the previous cycle)
//   mem_dout/mem_a/mem_wr   RAM write byte, byte address, write strobe
//   io_full              IO output buffer full
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IO_HI  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [31:0]       ic_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_full
);

`ifdef IO_WAIT_EN
  typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_IO} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
`endif

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic              last_grant, last_grant_n;   // 1 = LSB was granted last
  logic              cur_ls, cur_ls_n;           // current transaction belongs to the LSB
  logic [1:0]        cur_last, cur_last_n;       // index of the final byte
  logic [ADDR_W-1:0] cur_addr, cur_addr_n;
  logic [31:0]       cur_wdata, cur_wdata_n;
  logic [31:0]       rd_buf, rd_buf_n;
  logic              paused;
  logic              ic_valid_n, ls_done_n;
  logic [31:0]       ic_data_n, ls_rdata_n;

  logic              ic_ok, ls_ok, pick_ls, wr_go, io_region, io_stall;
  logic [1:0]        ls_last, wr_idx, wr_last;
  logic [ADDR_W-1:0] wr_base, wr_addr;
  logic [31:0]       wr_data;

  assign ls_last = (ls_size == 2'd0) ? 2'd0 : (ls_size == 2'd1) ? 2'd1 : 2'd3;

`ifndef IO_WAIT_EN
  logic unused_io;
  assign unused_io = io_full & io_region;
`endif

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    cur_ls_n     = cur_ls;
    cur_last_n   = cur_last;
    cur_addr_n   = cur_addr;
    cur_wdata_n  = cur_wdata;
    rd_buf_n     = rd_buf;
    ic_valid_n   = 1'b0;
    ls_done_n    = 1'b0;
    ic_data_n    = ic_data;
    ls_rdata_n   = ls_rdata;
    mem_a        = '0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    ic_ok        = ic_req && !clear;
    ls_ok        = ls_req && (ls_we || !clear);
    pick_ls      = 1'b0;
    wr_go        = 1'b0;
    wr_idx       = cnt;
    wr_last      = cur_last;
    wr_base      = cur_addr;
    wr_data      = cur_wdata;
    wr_addr      = cur_addr + ADDR_W'(cnt);
    io_region    = 1'b0;
    io_stall     = 1'b0;

    if (rdy && !rst) begin
      case (state)
        IDLE: begin
          // A done pulse still high means its requester has not dropped req yet.
          if (!ic_valid && !ls_done && (ic_ok || ls_ok)) begin
            pick_ls      = ls_ok && (!ic_ok || !last_grant);
            last_grant_n = pick_ls;
            cur_ls_n     = pick_ls;
            cnt_n        = 2'd0;
            rd_buf_n     = 32'd0;
            cur_addr_n   = pick_ls ? ls_addr : ic_addr;
            cur_last_n   = pick_ls ? ls_last : 2'd3;
            cur_wdata_n  = ls_wdata;
            if (pick_ls && ls_we) begin
              wr_go   = 1'b1;
              wr_idx  = 2'd0;
              wr_last = ls_last;
              wr_base = ls_addr;
              wr_data = ls_wdata;
            end else begin
              mem_a   = cur_addr_n;
              state_n = READ;
            end
          end
        end
        READ: begin
          if (clear) begin
            state_n = IDLE;
            cnt_n   = 2'd0;
          end else if (paused) begin
            // mem_din is stale after a pause: re-issue the base address and start over.
            mem_a    = cur_addr;
            cnt_n    = 2'd0;
            rd_buf_n = 32'd0;
          end else begin
            rd_buf_n[{cnt, 3'b000} +: 8] = mem_din;
            if (cnt == cur_last) begin
              state_n = IDLE;
              cnt_n   = 2'd0;
              if (cur_ls) begin
                ls_done_n  = 1'b1;
                ls_rdata_n = rd_buf_n;
              end else begin
                ic_valid_n = 1'b1;
                ic_data_n  = rd_buf_n;
              end
            end else begin
              cnt_n = cnt + 2'd1;
              mem_a = cur_addr + ADDR_W'(cnt_n);
            end
          end
        end
        WRITE: wr_go = 1'b1;
`ifdef IO_WAIT_EN
        WAIT_IO: wr_go = 1'b1;
`endif
        default: state_n = IDLE;
      endcase

      // One store byte per cycle; clear has no effect on stores.
      if (wr_go) begin
        wr_addr   = wr_base + ADDR_W'(wr_idx);
        io_region = (wr_addr[IO_HI:IO_HI-1] == 2'b11);
`ifdef IO_WAIT_EN
        io_stall  = io_full && io_region;
`endif
        if (io_stall) begin
`ifdef IO_WAIT_EN
          state_n = WAIT_IO;
`endif
          cnt_n = wr_idx;
        end else begin
          mem_wr   = 1'b1;
          mem_a    = wr_addr;
          mem_dout = wr_data[{wr_idx, 3'b000} +: 8];
          if (wr_idx == wr_last) begin
            state_n   = IDLE;
            cnt_n     = 2'd0;
            ls_done_n = 1'b1;
          end else begin
            state_n = WRITE;
            cnt_n   = wr_idx + 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_grant <= 1'b0;
      cur_ls     <= 1'b0;
      cur_last   <= 2'd0;
      cur_addr   <= '0;
      cur_wdata  <= 32'd0;
      rd_buf     <= 32'd0;
      paused     <= 1'b0;
      ic_valid   <= 1'b0;
      ic_data    <= 32'd0;
      ls_done    <= 1'b0;
      ls_rdata   <= 32'd0;
    end else begin
      // Remembers that the previous cycle was paused so an in-flight read restarts.
      paused <= !rdy;
      if (rdy) begin
        state      <= state_n;
        cnt        <= cnt_n;
        last_grant <= last_grant_n;
        cur_ls     <= cur_ls_n;
        cur_last   <= cur_last_n;
        cur_addr   <= cur_addr_n;
        cur_wdata  <= cur_wdata_n;
        rd_buf     <= rd_buf_n;
        ic_valid   <= ic_valid_n;
        ic_data    <= ic_data_n;
        ls_done    <= ls_done_n;
        ls_rdata   <= ls_rdata_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
  logic        clk, rst, rdy, clear;
  logic        ic_req, ic_valid;
  logic [31:0] ic_addr, ic_data;
  logic        ls_req, ls_we, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_full;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, wr_at, done_at;
  logic [31:0] wa;
  logic [7:0]  wd;

  mem_ctrl #(.ADDR_W(32), .IO_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_full(io_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-byte RAM aliased on mem_a[7:0]; read data appears one cycle after the address.
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hC3;
      ram[0]   <= 8'h13;
      ram[1]   <= 8'h05;
      ram[2]   <= 8'hA0;
      ram[3]   <= 8'h00;
      ram[254] <= 8'h11;
      ram[255] <= 8'h22;
    end else if (mem_wr) begin
      ram[mem_a[7:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_done(input logic is_ic, input int max, output int l);
    int k;
    l = 0;
    k = 0;
    while (l == 0 && k < max) begin
      k++;
      @(negedge clk);
      #1;
      if (is_ic ? ic_valid : ls_done) l = k;
    end
  endtask

  task automatic read_txn(input logic is_ic, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] exp, input string tag);
    int n, l;
    logic wr_seen;
    n = is_ic ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    @(negedge clk);
    if (is_ic) begin
      ic_req = 1'b1; ic_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = 1'b0; ls_size = size; ls_addr = addr;
    end
    #1;
    check({tag, "_a0"}, mem_a, addr);
    wr_seen = mem_wr;
    l = 0;
    for (int k = 1; k <= 10 && l == 0; k++) begin
      @(negedge clk);
      #1;
      wr_seen |= mem_wr;
      if (k < n) check({tag, "_a"}, mem_a, addr + 32'(k));
      if (is_ic ? ic_valid : ls_done) l = k;
    end
    check({tag, "_lat"}, 32'(l), 32'(n + 1));
    check({tag, "_data"}, is_ic ? ic_data : ls_rdata, exp);
    check({tag, "_wr"}, 32'(wr_seen), 32'd0);
    ic_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic store_txn(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                           input int clear_at, input string tag);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      clear = (k == clear_at);
      #1;
      check({tag, "_wr"}, 32'(mem_wr), 32'(k < n));
      if (k < n) begin
        check({tag, "_a"}, mem_a, addr + 32'(k));
        check({tag, "_d"}, 32'(mem_dout), 32'(wdata[8*k +: 8]));
      end
      check({tag, "_done"}, 32'(ls_done), 32'(k == n));
    end
    clear = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
    ic_req = 1'b0; ic_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_ic_valid", 32'(ic_valid), 32'd0);
    check("rst_ic_data", ic_data, 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    read_txn(1'b1, 32'h100, 2'd2, 32'h00A00513, "fetch");

    // Both request, last grant was IC: LSB first, IC right after the turnaround cycle.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h2001;
    #1;
    check("rr_ls_first", mem_a, 32'h2001);
    wait_done(1'b0, 6, lat);
    check("rr_ls_lat", 32'(lat), 32'd3);
    check("rr_ls_data", ls_rdata, 32'h0000A005);
    check("rr_turnaround", mem_a, 32'd0);
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    check("rr_ic_grant", mem_a, 32'h100);
    wait_done(1'b1, 8, lat);
    check("rr_ic_lat", 32'(lat), 32'd5);
    check("rr_ic_data", ic_data, 32'h00A00513);
    ic_req = 1'b0;

    store_txn(32'h40, 2'd2, 32'hDEADBEEF, -1, "store");

    // Last grant was LSB: IC wins, then the 1-byte load.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h40;
    #1;
    check("rr_ic_first", mem_a, 32'h100);
    wait_done(1'b1, 8, lat);
    check("rr2_ic_lat", 32'(lat), 32'd5);
    ic_req = 1'b0;
    wait_done(1'b0, 8, lat);
    check("rr2_ls_lat", 32'(lat), 32'd3);
    check("rr2_ls_data", ls_rdata, 32'h000000EF);
    ls_req = 1'b0;

    read_txn(1'b0, 32'h40, 2'd2, 32'hDEADBEEF, "ld4");
    read_txn(1'b0, 32'h42, 2'd3, 32'h8687DEAD, "ld_size3");
    read_txn(1'b1, 32'hFFFFFFFE, 2'd2, 32'h05132211, "wrap");

    // Flush at T2 of a fetch aborts it; clear also blocks a new IC grant.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    #1;
    check("clr_no_grant", mem_a, 32'd0);
    check("clr_no_valid", 32'(ic_valid), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_regrant", mem_a, 32'h100);
    wait_done(1'b1, 8, lat);
    check("clr_refetch_lat", 32'(lat), 32'd5);
    check("clr_refetch_data", ic_data, 32'h00A00513);
    ic_req = 1'b0;

    store_txn(32'h80, 2'd2, 32'h01020304, 2, "store_clr");
    read_txn(1'b0, 32'h80, 2'd2, 32'h01020304, "ld_clr");

    // Pause at T2 of a fetch: restart from the base address on resume.
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    #1;
    check("pause_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("pause_base", mem_a, 32'h100);
    wait_done(1'b1, 8, lat);
    check("pause_lat", 32'(lat), 32'd5);
    check("pause_data", ic_data, 32'h00A00513);
    ic_req = 1'b0;

    // 1-byte IO store with io_full high for the first 3 cycles.
    wr_at = -1; done_at = -1; wa = 32'd0; wd = 8'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h77;
        io_full = 1'b1;
      end
      if (k == 3) io_full = 1'b0;
      #1;
      if (mem_wr && wr_at < 0) begin wr_at = k; wa = mem_a; wd = mem_dout; end
      if (ls_done && done_at < 0) begin done_at = k; ls_req = 1'b0; ls_we = 1'b0; end
    end
`ifdef IO_WAIT_EN
    check("io_wr_cycle", 32'(wr_at), 32'd3);
    check("io_done_cycle", 32'(done_at), 32'd4);
`else
    check("io_wr_cycle", 32'(wr_at), 32'd0);
    check("io_done_cycle", 32'(done_at), 32'd1);
`endif
    check("io_addr", wa, 32'h30000);
    check("io_byte", 32'(wd), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
